// File: rtl/svc_axil_pkg.sv
// rtl/svc_axil_pkg.sv - shared AXI-Lite response codes and bus-error pattern
package svc_axil_pkg;

    typedef enum logic [1:0] {
        AXIL_RESP_OKAY   = 2'b00,
        AXIL_RESP_EXOKAY = 2'b01,
        AXIL_RESP_SLVERR = 2'b10,
        AXIL_RESP_DECERR = 2'b11
    } axil_resp_e;

    localparam logic [31:0] AXIL_BUS_ERR_PATTERN = 32'hADD1EBAD;

    // Number of byte-offset address bits below the word index.
    function automatic int unsigned axil_addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/svc_axil_regfile_wr.sv
// rtl/svc_axil_regfile_wr.sv - AW/W holding slots, register storage and B channel
module svc_axil_regfile_wr
    import svc_axil_pkg::*;
#(
    parameter int                  AW       = 8,
    parameter int                  DW       = 32,
    parameter int                  NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_axil_awvalid,
    input  logic [AW-1:0]                s_axil_awaddr,
    output logic                         s_axil_awready,
    input  logic                         s_axil_wvalid,
    input  logic [DW-1:0]                s_axil_wdata,
    input  logic [DW/8-1:0]              s_axil_wstrb,
    output logic                         s_axil_wready,
    output logic                         s_axil_bvalid,
    output logic [1:0]                   s_axil_bresp,
    input  logic                         s_axil_bready,
    output logic [NUM_REGS-1:0][DW-1:0]  regs,
    output logic [NUM_REGS-1:0]          wr_pulse
);
    localparam int STRBW    = DW / 8;
    localparam int ADDR_LSB = axil_addr_lsb(DW);
    localparam int IDXW     = AW - ADDR_LSB;
    localparam int SELW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic                        aw_full_q, aw_full_d;
    logic [IDXW-1:0]             aw_idx_q, aw_idx_d;
    logic                        w_full_q, w_full_d;
    logic [DW-1:0]               w_data_q, w_data_d;
    logic [STRBW-1:0]            w_strb_q, w_strb_d;
    logic                        bvalid_q, bvalid_d;
    axil_resp_e                  bresp_q, bresp_d;
    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]         wr_pulse_q, wr_pulse_d;

    logic            do_write, aw_hs, w_hs, in_range, wr_ok;
    logic [SELW-1:0] sel;

    if (ADDR_LSB > 0) begin : g_unused_lsb
        logic unused_awaddr_lsb;
        assign unused_awaddr_lsb = ^s_axil_awaddr[ADDR_LSB-1:0];
    end

    assign sel      = aw_idx_q[SELW-1:0];
    assign in_range = (32'(aw_idx_q) < 32'(NUM_REGS));
    assign wr_ok    = in_range && !RO_MASK[sel];

    // A pending B response blocks the next write unless it retires this cycle.
    assign do_write       = aw_full_q && w_full_q && (!bvalid_q || s_axil_bready);
    assign s_axil_awready = !aw_full_q || do_write;
    assign s_axil_wready  = !w_full_q || do_write;
    assign aw_hs          = s_axil_awvalid && s_axil_awready;
    assign w_hs           = s_axil_wvalid && s_axil_wready;

    always_comb begin
        aw_full_d  = aw_full_q;
        aw_idx_d   = aw_idx_q;
        w_full_d   = w_full_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (do_write) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_ok ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
            if (wr_ok) begin
                wr_pulse_d[sel] = 1'b1;
                for (int b = 0; b < STRBW; b++) begin
                    if (w_strb_q[b]) begin
                        regs_d[sel][8*b +: 8] = w_data_q[8*b +: 8];
                    end
                end
            end
        end else if (s_axil_bready) begin
            bvalid_d = 1'b0;
        end
        if (aw_hs) begin
            aw_full_d = 1'b1;
            aw_idx_d  = s_axil_awaddr[AW-1:ADDR_LSB];
        end
        if (w_hs) begin
            w_full_d = 1'b1;
            w_data_d = s_axil_wdata;
            w_strb_d = s_axil_wstrb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= AXIL_RESP_OKAY;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_full_q  <= aw_full_d;
            aw_idx_q   <= aw_idx_d;
            w_full_q   <= w_full_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign regs          = regs_q;
    assign wr_pulse      = wr_pulse_q;

endmodule

// File: rtl/svc_axil_regfile.sv
// rtl/svc_axil_regfile.sv - AXI-Lite register file with read-only status slots
module svc_axil_regfile
    import svc_axil_pkg::*;
#(
    parameter int                  AXIL_ADDR_WIDTH = 8,
    parameter int                  AXIL_DATA_WIDTH = 32,
    parameter int                  NUM_REGS        = 8,
    parameter logic [NUM_REGS-1:0] RO_MASK         = '0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      s_axil_awvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0]                s_axil_awaddr,
    output logic                                      s_axil_awready,
    input  logic                                      s_axil_wvalid,
    input  logic [AXIL_DATA_WIDTH-1:0]                s_axil_wdata,
    input  logic [AXIL_DATA_WIDTH/8-1:0]              s_axil_wstrb,
    output logic                                      s_axil_wready,
    output logic                                      s_axil_bvalid,
    output logic [1:0]                                s_axil_bresp,
    input  logic                                      s_axil_bready,
    input  logic                                      s_axil_arvalid,
    input  logic [AXIL_ADDR_WIDTH-1:0]                s_axil_araddr,
    output logic                                      s_axil_arready,
    output logic                                      s_axil_rvalid,
    output logic [AXIL_DATA_WIDTH-1:0]                s_axil_rdata,
    output logic [1:0]                                s_axil_rresp,
    input  logic                                      s_axil_rready,
    output logic [NUM_REGS-1:0][AXIL_DATA_WIDTH-1:0]  regs,
    input  logic [NUM_REGS-1:0][AXIL_DATA_WIDTH-1:0]  ro_val,
    output logic [NUM_REGS-1:0]                       wr_pulse
);
    localparam int AW       = AXIL_ADDR_WIDTH;
    localparam int DW       = AXIL_DATA_WIDTH;
    localparam int ADDR_LSB = axil_addr_lsb(DW);
    localparam int IDXW     = AW - ADDR_LSB;
    localparam int SELW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    svc_axil_regfile_wr #(
        .AW       (AW),
        .DW       (DW),
        .NUM_REGS (NUM_REGS),
        .RO_MASK  (RO_MASK)
    ) u_wr (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awvalid (s_axil_awvalid),
        .s_axil_awaddr  (s_axil_awaddr),
        .s_axil_awready (s_axil_awready),
        .s_axil_wvalid  (s_axil_wvalid),
        .s_axil_wdata   (s_axil_wdata),
        .s_axil_wstrb   (s_axil_wstrb),
        .s_axil_wready  (s_axil_wready),
        .s_axil_bvalid  (s_axil_bvalid),
        .s_axil_bresp   (s_axil_bresp),
        .s_axil_bready  (s_axil_bready),
        .regs           (regs),
        .wr_pulse       (wr_pulse)
    );

    logic            rvalid_q;
    logic [DW-1:0]   rdata_q, rdata_d;
    axil_resp_e      rresp_q, rresp_d;
    logic [IDXW-1:0] ar_idx;
    logic [SELW-1:0] ar_sel;
    logic            ar_in_range, ar_hs;

    if (ADDR_LSB > 0) begin : g_unused_lsb
        logic unused_araddr_lsb;
        assign unused_araddr_lsb = ^s_axil_araddr[ADDR_LSB-1:0];
    end

    assign ar_idx         = s_axil_araddr[AW-1:ADDR_LSB];
    assign ar_sel         = ar_idx[SELW-1:0];
    assign ar_in_range    = (32'(ar_idx) < 32'(NUM_REGS));
    assign s_axil_arready = !rvalid_q || s_axil_rready;
    assign ar_hs          = s_axil_arvalid && s_axil_arready;

    // Sampling the register outputs here gives the pre-write value on a same-cycle collision.
    always_comb begin
        rdata_d = regs[ar_sel];
        rresp_d = AXIL_RESP_OKAY;
        if (!ar_in_range) begin
            rdata_d = DW'(AXIL_BUS_ERR_PATTERN);
            rresp_d = AXIL_RESP_SLVERR;
        end else if (RO_MASK[ar_sel]) begin
            rdata_d = ro_val[ar_sel];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= AXIL_RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end else if (s_axil_rready) begin
            rvalid_q <= 1'b0;
        end
    end

    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = rresp_q;

endmodule

// File: tb/tb_svc_axil_regfile.sv
// tb/tb_svc_axil_regfile.sv - directed and randomized bench for svc_axil_regfile
module tb_svc_axil_regfile;
    localparam int              NR = 8;
    localparam logic [NR-1:0]   RO = 8'h80;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 awvalid = 1'b0, awready;
    logic [7:0]           awaddr = '0;
    logic                 wvalid = 1'b0, wready;
    logic [31:0]          wdata = '0;
    logic [3:0]           wstrb = '0;
    logic                 bvalid, bready = 1'b0;
    logic [1:0]           bresp;
    logic                 arvalid = 1'b0, arready;
    logic [7:0]           araddr = '0;
    logic                 rvalid, rready = 1'b0;
    logic [31:0]          rdata;
    logic [1:0]           rresp;
    logic [NR-1:0][31:0]  regs;
    logic [NR-1:0][31:0]  ro_val = '0;
    logic [NR-1:0]        wr_pulse;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] m_regs [NR];

    always #5 clk = ~clk;

    svc_axil_regfile #(
        .AXIL_ADDR_WIDTH (8),
        .AXIL_DATA_WIDTH (32),
        .NUM_REGS        (NR),
        .RO_MASK         (RO)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_axil_awvalid (awvalid),
        .s_axil_awaddr  (awaddr),
        .s_axil_awready (awready),
        .s_axil_wvalid  (wvalid),
        .s_axil_wdata   (wdata),
        .s_axil_wstrb   (wstrb),
        .s_axil_wready  (wready),
        .s_axil_bvalid  (bvalid),
        .s_axil_bresp   (bresp),
        .s_axil_bready  (bready),
        .s_axil_arvalid (arvalid),
        .s_axil_araddr  (araddr),
        .s_axil_arready (arready),
        .s_axil_rvalid  (rvalid),
        .s_axil_rdata   (rdata),
        .s_axil_rresp   (rresp),
        .s_axil_rready  (rready),
        .regs           (regs),
        .ro_val         (ro_val),
        .wr_pulse       (wr_pulse)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < NR; i++) check(tag, regs[i], m_regs[i]);
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    // Reference write: word index = byte address / 4; RO or out-of-range -> SLVERR, no change.
    function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        int          idx = int'(a) / 4;
        logic [31:0] mask = strb_mask(s);
        if (idx >= NR || RO[idx]) return 2'b10;
        m_regs[idx] = (m_regs[idx] & ~mask) | (d & mask);
        return 2'b00;
    endfunction

    task automatic model_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        int idx = int'(a) / 4;
        if (idx >= NR) begin
            d = 32'hADD1EBAD;
            r = 2'b10;
        end else if (RO[idx]) begin
            d = ro_val[idx];
            r = 2'b00;
        end else begin
            d = m_regs[idx];
            r = 2'b00;
        end
    endtask

    task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_go, w_go;
        int n = 0;
        awvalid = 1'b1; awaddr = a; wvalid = 1'b1; wdata = d; wstrb = s; bready = 1'b1;
        while (!(aw_done && w_done) && n < 20) begin
            @(negedge clk);
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge clk); #1;
            if (aw_go) begin awvalid = 1'b0; aw_done = 1; end
            if (w_go) begin wvalid = 1'b0; w_done = 1; end
            n++;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_accept", 32'(aw_done && w_done), 32'd1);
        n = 0;
        while (!bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("wr_bvalid", 32'(bvalid), 32'd1);
        resp = bresp;
        @(posedge clk); #1;
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit go = 0;
        int n = 0;
        arvalid = 1'b1; araddr = a; rready = 1'b1;
        while (!go && n < 20) begin
            @(negedge clk);
            go = arready;
            @(posedge clk); #1;
            n++;
        end
        arvalid = 1'b0;
        check("rd_accept", 32'(go), 32'd1);
        check("rd_latency", 32'(rvalid), 32'd1);
        d = rdata;
        resp = rresp;
        @(posedge clk); #1;
        rready = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d, ed, wd [4];
        logic [1:0]  r, er;
        logic [7:0]  a;
        logic [3:0]  s;
        int          bcount;

        for (int i = 0; i < NR; i++) begin
            ro_val[i] = $urandom;
            m_regs[i] = '0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_wr_pulse", 32'(wr_pulse), 32'd0);
        check_regs("rst_regs");

        // AW at t, W at t+3 -> bvalid at t+4
        awvalid = 1'b1; awaddr = 8'h04;
        @(negedge clk);
        check("split_awready", 32'(awready), 32'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        wvalid = 1'b1; wdata = 32'hCAFEF00D; wstrb = 4'hF;
        @(posedge clk); #1;
        wvalid = 1'b0;
        check("split_t3_bvalid", 32'(bvalid), 32'd0);
        @(posedge clk); #1;
        check("split_t4_bvalid", 32'(bvalid), 32'd1);
        check("split_bresp", 32'(bresp), 32'd0);
        check("split_reg1", regs[1], 32'hCAFEF00D);
        check("split_pulse", 32'(wr_pulse), 32'h02);
        er = model_write(8'h04, 32'hCAFEF00D, 4'hF);
        @(posedge clk); #1;
        check("split_pulse_1cyc", 32'(wr_pulse), 32'd0);
        check("split_bvalid_hold", 32'(bvalid), 32'd1);
        check("split_bresp_hold", 32'(bresp), 32'(er));
        bready = 1'b1;
        @(posedge clk); #1;
        check("split_bvalid_clr", 32'(bvalid), 32'd0);
        bready = 1'b0;

        // Byte strobe partial write
        axi_write(8'h08, 32'h11223344, 4'hF, r);
        er = model_write(8'h08, 32'h11223344, 4'hF);
        check("full_bresp", 32'(r), 32'(er));
        axi_write(8'h08, 32'h000000AA, 4'h1, r);
        er = model_write(8'h08, 32'h000000AA, 4'h1);
        check("strb_bresp", 32'(r), 32'(er));
        check("strb_reg2", regs[2], 32'h112233AA);
        check_regs("strb_regs");

        // Out-of-range read and write
        axi_read(8'h40, d, r);
        check("oor_rdata", d, 32'hADD1EBAD);
        check("oor_rresp", 32'(r), 32'd2);
        axi_write(8'h40, 32'hFFFFFFFF, 4'hF, r);
        check("oor_bresp", 32'(r), 32'd2);
        check_regs("oor_regs");

        // Read-only register
        ro_val[7] = 32'h5A5A5A5A;
        axi_read(8'h1C, d, r);
        check("ro_rdata", d, 32'h5A5A5A5A);
        check("ro_rresp", 32'(r), 32'd0);
        axi_write(8'h1C, 32'h12345678, 4'hF, r);
        check("ro_bresp", 32'(r), 32'd2);
        check_regs("ro_regs");

        // R backpressure with a second AR waiting
        rready = 1'b0; arvalid = 1'b1; araddr = 8'h04;
        @(negedge clk);
        check("bp_arready0", 32'(arready), 32'd1);
        @(posedge clk); #1;
        araddr = 8'h08;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_arready_low", 32'(arready), 32'd0);
            check("bp_rvalid", 32'(rvalid), 32'd1);
            check("bp_rdata_stable", rdata, m_regs[1]);
        end
        rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("bp_second_rvalid", 32'(rvalid), 32'd1);
        check("bp_second_rdata", rdata, m_regs[2]);
        @(posedge clk); #1;
        rready = 1'b0;

        // Same-cycle read and write to one register returns the old value
        awvalid = 1'b1; awaddr = 8'h0C; wvalid = 1'b1; wdata = 32'hDEADBEEF; wstrb = 4'hF; bready = 1'b1;
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 8'h0C; rready = 1'b1;
        @(posedge clk); #1;
        arvalid = 1'b0;
        check("coll_rvalid", 32'(rvalid), 32'd1);
        check("coll_rdata_old", rdata, m_regs[3]);
        er = model_write(8'h0C, 32'hDEADBEEF, 4'hF);
        check("coll_bvalid", 32'(bvalid), 32'd1);
        check("coll_bresp", 32'(bresp), 32'(er));
        check("coll_reg3", regs[3], m_regs[3]);
        check("coll_pulse", 32'(wr_pulse), 32'h08);
        @(posedge clk); #1;
        bready = 1'b0; rready = 1'b0;

        // Back-to-back writes then reads
        bready = 1'b1; awvalid = 1'b1; wvalid = 1'b1; wstrb = 4'hF; bcount = 0;
        for (int i = 0; i < 4; i++) begin
            wd[i] = $urandom;
            awaddr = 8'(i * 4); wdata = wd[i];
            @(negedge clk);
            check("tp_wr_ready", 32'(awready && wready), 32'd1);
            bcount += int'(bvalid);
            @(posedge clk); #1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bcount += int'(bvalid);
            @(posedge clk); #1;
        end
        bready = 1'b0;
        check("tp_bvalid_cycles", 32'(bcount), 32'd4);
        for (int i = 0; i < 4; i++) er = model_write(8'(i * 4), wd[i], 4'hF);
        check_regs("tp_regs");
        rready = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            araddr = 8'(i * 4);
            @(negedge clk);
            check("tp_arready", 32'(arready), 32'd1);
            @(posedge clk); #1;
            check("tp_rvalid", 32'(rvalid), 32'd1);
            check("tp_rdata", rdata, m_regs[i]);
        end
        arvalid = 1'b0;
        @(posedge clk); #1;
        rready = 1'b0;

        // Randomized traffic against the reference model
        for (int it = 0; it < 60; it++) begin
            a = 8'($urandom_range(0, 79));
            if ($urandom_range(0, 1) == 0) begin
                ro_val[7] = $urandom;
                model_read(a, ed, er);
                axi_read(a, d, r);
                check("rnd_rdata", d, ed);
                check("rnd_rresp", 32'(r), 32'(er));
            end else begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                axi_write(a, d, s, r);
                er = model_write(a, d, s);
                check("rnd_bresp", 32'(r), 32'(er));
                check_regs("rnd_regs");
            end
        end

        // Reset with AW accepted and W never sent
        awvalid = 1'b1; awaddr = 8'h04; bready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        awvalid = 1'b0; rst_n = 1'b1;
        for (int i = 0; i < NR; i++) m_regs[i] = '0;
        check("mid_rst_awready", 32'(awready), 32'd1);
        check("mid_rst_wready", 32'(wready), 32'd1);
        check("mid_rst_arready", 32'(arready), 32'd1);
        check_regs("mid_rst_regs");
        wvalid = 1'b1; wdata = 32'h55555555; wstrb = 4'hF;
        @(posedge clk); #1;
        wvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("mid_rst_no_bvalid", 32'(bvalid), 32'd0);
            check("mid_rst_no_pulse", 32'(wr_pulse), 32'd0);
            @(posedge clk); #1;
        end
        check_regs("mid_rst_regs_after");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
